fetch_decode_unit: RTL and testbench

//  Front end of the single-cycle MIPS datapath: owns the PC, fetches 32-bit words from an

---
 rtl/fetch_decode_unit.sv | 166 ++++++++++++++++
 tb/tb_fetch_decode_unit.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_decode_unit.sv
// Front end of the single-cycle MIPS datapath: PC ownership, variable-latency instruction
// fetch, field split and main-control decode, issued one instruction at a time over valid/ready.
module fetch_decode_unit #(
    parameter int              PC_W     = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic [31:0]     imem_rdata,
    input  logic            imem_valid,
    output logic            dp_valid,
    input  logic            dp_ready,
    output logic [4:0]      rs,
    output logic [4:0]      rt,
    output logic [4:0]      rd,
    output logic [15:0]     SEin,
    output logic [5:0]      FuncCode,
    output logic            Regsel,
    output logic            ALUsel,
    output logic [1:0]      ALUOp,
    output logic            MemRead,
    output logic            MemWrite,
    output logic            MemToRegSel,
    output logic            RegWrite,
    input  logic            Zero,
    output logic            illegal,
    output logic [PC_W-1:0] pc
);

    typedef enum logic [1:0] {
        S_FETCH,
        S_WAIT,
        S_ISSUE
    } state_t;

    typedef struct packed {
        logic       regsel;
        logic       alusel;
        logic [1:0] aluop;
        logic       memread;
        logic       memwrite;
        logic       memtoreg;
        logic       regwrite;
        logic       is_beq;
        logic       is_j;
        logic       is_illegal;
    } ctrl_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    function automatic ctrl_t decode(input logic [5:0] op);
        ctrl_t c;
        c = '0;
        case (op)
            OP_RTYPE: begin
                c.regsel   = 1'b1;
                c.aluop    = 2'b10;
                c.regwrite = 1'b1;
            end
            OP_LW: begin
                c.alusel   = 1'b1;
                c.memread  = 1'b1;
                c.memtoreg = 1'b1;
                c.regwrite = 1'b1;
            end
            OP_SW: begin
                c.alusel   = 1'b1;
                c.memwrite = 1'b1;
            end
            OP_BEQ: begin
                c.aluop  = 2'b01;
                c.is_beq = 1'b1;
            end
            OP_J:    c.is_j = 1'b1;
            default: c.is_illegal = 1'b1;
        endcase
        return c;
    endfunction

    // Branch offset is a word offset; j keeps the upper nibble of the incremented PC.
    function automatic logic [PC_W-1:0] next_pc(
        input logic [PC_W-1:0] cur,
        input logic [31:0]     instr,
        input ctrl_t           c,
        input logic            zero
    );
        logic [PC_W-1:0] pc4;
        logic [PC_W-1:0] boff;
        pc4  = cur + PC_W'(4);
        boff = {{(PC_W-18){instr[15]}}, instr[15:0], 2'b00};
        if (c.is_beq && zero)
            return pc4 + boff;
        else if (c.is_j)
            return {pc4[PC_W-1:28], instr[25:0], 2'b00};
        else
            return pc4;
    endfunction

    state_t          r_state;
    state_t          w_state_nxt;
    logic [PC_W-1:0] r_pc;
    logic [31:0]     r_instr;
    ctrl_t           r_ctrl;
    logic            w_capture;
    logic            w_hs;
    logic [PC_W-1:0] w_pc_nxt;

    assign w_capture = (r_state == S_WAIT) && imem_valid;
    assign w_hs      = (r_state == S_ISSUE) && dp_ready;
    assign w_pc_nxt  = next_pc(r_pc, r_instr, r_ctrl, Zero);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_FETCH: w_state_nxt = S_WAIT;
            S_WAIT:  if (imem_valid) w_state_nxt = S_ISSUE;
            S_ISSUE: if (dp_ready) w_state_nxt = S_FETCH;
            default: w_state_nxt = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_FETCH;
            r_pc    <= RESET_PC;
            r_instr <= '0;
            r_ctrl  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_capture) begin
                r_instr <= imem_rdata;
                r_ctrl  <= decode(imem_rdata[31:26]);
            end
            if (w_hs)
                r_pc <= w_pc_nxt;
        end
    end

    // Handshake-side outputs are masked while rst is held so nothing leaks out during reset.
    assign imem_req  = !rst && ((r_state == S_FETCH) || (r_state == S_WAIT));
    assign imem_addr = r_pc;
    assign dp_valid  = !rst && (r_state == S_ISSUE);
    assign illegal   = !rst && w_hs && r_ctrl.is_illegal;
    assign pc        = r_pc;

    assign rs       = r_instr[25:21];
    assign rt       = r_instr[20:16];
    assign rd       = r_instr[15:11];
    assign SEin     = r_instr[15:0];
    assign FuncCode = r_instr[5:0];

    assign Regsel      = r_ctrl.regsel;
    assign ALUsel      = r_ctrl.alusel;
    assign ALUOp       = r_ctrl.aluop;
    assign MemRead     = r_ctrl.memread;
    assign MemWrite    = r_ctrl.memwrite;
    assign MemToRegSel = r_ctrl.memtoreg;
    assign RegWrite    = r_ctrl.regwrite;

endmodule

// File: tb/tb_fetch_decode_unit.sv
// Directed bench for fetch_decode_unit: drives an instruction-memory stub and a datapath
// handshake, checking fields, controls and PC flow against hand-computed values.
module tb_fetch_decode_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_valid;
    logic        dp_valid;
    logic        dp_ready;
    logic [4:0]  rs, rt, rd;
    logic [15:0] SEin;
    logic [5:0]  FuncCode;
    logic        Regsel, ALUsel;
    logic [1:0]  ALUOp;
    logic        MemRead, MemWrite, MemToRegSel, RegWrite;
    logic        Zero;
    logic        illegal;
    logic [31:0] pc;

    int errors = 0;
    int checks = 0;

    fetch_decode_unit #(.PC_W(32), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .imem_valid(imem_valid),
        .dp_valid(dp_valid), .dp_ready(dp_ready),
        .rs(rs), .rt(rt), .rd(rd), .SEin(SEin), .FuncCode(FuncCode),
        .Regsel(Regsel), .ALUsel(ALUsel), .ALUOp(ALUOp),
        .MemRead(MemRead), .MemWrite(MemWrite), .MemToRegSel(MemToRegSel),
        .RegWrite(RegWrite), .Zero(Zero), .illegal(illegal), .pc(pc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Controls packed as {Regsel,ALUsel,ALUOp,MemRead,MemWrite,MemToRegSel,RegWrite}.
    task automatic chk_ctrl(input string tag, input logic [7:0] exp);
        chk(tag, {Regsel, ALUsel, ALUOp, MemRead, MemWrite, MemToRegSel, RegWrite}, {24'h0, exp});
    endtask

    // Answer one fetch at exp_addr with the given latency; returns at the first ISSUE cycle.
    task automatic serve(input logic [31:0] exp_addr, input logic [31:0] word, input int lat);
        int n;
        n = 0;
        while (!imem_req && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("req_seen", imem_req, 1);
        chk("imem_addr", imem_addr, exp_addr);
        for (int i = 0; i < lat; i++) begin
            @(negedge clk);
            chk("req_held", imem_req, 1);
            chk("no_early_valid", dp_valid, 0);
        end
        imem_valid = 1'b1;
        imem_rdata = word;
        @(negedge clk);
        imem_valid = 1'b0;
        imem_rdata = 32'hDEAD_BEEF;
        chk("dp_valid", dp_valid, 1);
        chk("req_drop", imem_req, 0);
    endtask

    // Complete the handshake in the current ISSUE cycle.
    task automatic handshake(input logic zero, input logic exp_ill);
        dp_ready = 1'b1;
        Zero     = zero;
        #1;
        chk("illegal_hs", illegal, exp_ill);
        @(negedge clk);
        dp_ready = 1'b0;
        Zero     = 1'b0;
        chk("valid_drop", dp_valid, 0);
        chk("illegal_after", illegal, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        imem_rdata = 32'h0;
        imem_valid = 1'b0;
        dp_ready   = 1'b1;
        Zero       = 1'b0;
        repeat (3) @(negedge clk);

        // reset state, with dp_ready already high
        chk("rst_req", imem_req, 0);
        chk("rst_dpv", dp_valid, 0);
        chk("rst_pc", pc, 32'h0);
        chk("rst_rs", rs, 0);
        chk("rst_ill", illegal, 0);
        chk_ctrl("rst_ctrl", 8'b0000_0000);
        dp_ready = 1'b0;
        rst = 1'b0;

        // add $8,$9,$10
        serve(32'h0, 32'h012A4020, 1);
        chk("add_rs", rs, 9);
        chk("add_rt", rt, 10);
        chk("add_rd", rd, 8);
        chk("add_fn", FuncCode, 6'h20);
        chk_ctrl("add_ctrl", 8'b1010_0001);
        handshake(1'b0, 1'b0);

        // lw with 5 cycles of backpressure
        serve(32'h4, 32'h8D090004, 1);
        for (int i = 0; i < 5; i++) begin
            chk("lw_hold_v", dp_valid, 1);
            chk("lw_hold_pc", pc, 32'h4);
            chk("lw_hold_imm", SEin, 16'h0004);
            chk_ctrl("lw_ctrl", 8'b0100_1011);
            @(negedge clk);
        end
        chk("lw_rs", rs, 8);
        chk("lw_rt", rt, 9);
        handshake(1'b0, 1'b0);

        // walk to 0x10, then beq taken back to 0x0C
        serve(32'h8, 32'h00000020, 1);
        handshake(1'b0, 1'b0);
        serve(32'hC, 32'h00000020, 1);
        handshake(1'b0, 1'b0);
        serve(32'h10, 32'h1000FFFE, 1);
        chk_ctrl("beq_ctrl", 8'b0001_0000);
        handshake(1'b1, 1'b0);
        serve(32'hC, 32'h00000020, 1);
        handshake(1'b0, 1'b0);
        // beq not taken
        serve(32'h10, 32'h1000FFFE, 2);
        handshake(1'b0, 1'b0);

        // j to 0x20, then j 0x40 -> 0x100
        serve(32'h14, 32'h08000008, 1);
        chk_ctrl("j_ctrl", 8'b0000_0000);
        handshake(1'b0, 1'b0);
        serve(32'h20, 32'h08000040, 1);
        handshake(1'b1, 1'b0);

        // unsupported opcode 0x3F
        serve(32'h100, 32'hFC000000, 1);
        chk_ctrl("ill_ctrl", 8'b0000_0000);
        handshake(1'b0, 1'b1);

        // sw
        serve(32'h104, 32'hAD090008, 1);
        chk_ctrl("sw_ctrl", 8'b0100_0100);
        chk("sw_imm", SEin, 16'h0008);
        handshake(1'b0, 1'b0);

        // latency 4
        serve(32'h108, 32'h014B6022, 4);
        chk("l4_rd", rd, 12);
        chk("l4_fn", FuncCode, 6'h22);
        handshake(1'b0, 1'b0);

        // reset during WAIT; late response dropped
        chk("pre_rst_addr", imem_addr, 32'h10C);
        @(negedge clk);
        chk("in_wait", imem_req, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_pc", pc, 32'h0);
        chk("mid_rst_dpv", dp_valid, 0);
        chk("mid_rst_req", imem_req, 0);
        rst        = 1'b0;
        imem_valid = 1'b1;
        imem_rdata = 32'h8D090004;
        @(negedge clk);
        imem_valid = 1'b0;
        chk("late_drop_dpv", dp_valid, 0);
        chk("late_drop_req", imem_req, 1);
        serve(32'h0, 32'h012A4020, 1);
        chk_ctrl("post_rst_ctrl", 8'b1010_0001);
        chk("post_rst_rs", rs, 9);
        handshake(1'b0, 1'b0);
        chk("post_rst_next", imem_addr, 32'h4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
